vsa_mem_arbiter: RTL and testbench

VSA_MEM_ARBITER -- requirements
Module: vsa_mem_arbiter

---
 rtl/vsa_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_vsa_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsa_mem_arbiter.sv
// vsa_mem_arbiter: two-port (fetch/data) arbiter in front of a single-ported
// memory with a one-cycle read latency. One access completes every two cycles.
module vsa_mem_arbiter #(
  parameter bit RR_EN     = 1'b1,
  parameter bit INIT_LAST = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [4:0]  if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [11:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [4:0]  d_addr,
  input  logic [4:0]  d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [4:0]  d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [4:0]  mem_addr,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata
);

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 12;
  localparam int unsigned DDW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;    // 1 = data port granted last
  logic             win_q, win_d;      // 1 = data port owns current access
  logic             wr_q, wr_d;        // latched data store
  logic [AW-1:0]    addr_q, addr_d;
  logic [DDW-1:0]   wdata_q, wdata_d;
  logic             arb_win;

  // Winner among the requests sampled this edge (1 = data port)
  always_comb begin
    arb_win = d_req;
    if (if_req && d_req) begin
      arb_win = RR_EN ? ~last_q : 1'b1;
    end
  end

  // State and latched-request registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= INIT_LAST;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state, arbitration and output decode
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_gnt    = 1'b0;
    if_valid  = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_valid   = 1'b0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) begin
          if (win_q) begin
            d_valid = 1'b1;
            d_rdata = wr_q ? '0 : mem_rdata[DDW-1:0];
          end else begin
            if_valid = 1'b1;
            if_rdata = mem_rdata;
          end
        end
        if (if_req || d_req) begin
          state_d = ACCESS;
          last_d  = arb_win;
          win_d   = arb_win;
          wr_d    = arb_win & d_wr;
          addr_d  = arb_win ? d_addr : if_addr;
          wdata_d = arb_win ? d_wdata : '0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d   = RESP;
        mem_en    = 1'b1;
        mem_we    = win_q & wr_q;
        mem_addr  = addr_q;
        mem_wdata = DW'(wdata_q);
        if_gnt    = ~win_q;
        d_gnt     = win_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vsa_mem_arbiter.sv
// Bench for vsa_mem_arbiter: a round-robin and a fixed-priority instance share
// one stimulus stream; each has its own memory and transaction-level model.
module tb_vsa_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_wr;
  logic [4:0]  if_addr, d_addr, d_wdata;

  logic        if_gnt0, if_valid0, d_gnt0, d_valid0, mem_en0, mem_we0;
  logic [11:0] if_rdata0, mem_wdata0;
  logic [4:0]  d_rdata0, mem_addr0;
  logic        if_gnt1, if_valid1, d_gnt1, d_valid1, mem_en1, mem_we1;
  logic [11:0] if_rdata1, mem_wdata1;
  logic [4:0]  d_rdata1, mem_addr1;

  logic [11:0] mem0 [32];
  logic [11:0] mem1 [32];
  logic [11:0] rd0 = '0;
  logic [11:0] rd1 = '0;
  logic        mem_ready = 1'b0;

  int ntests = 0;
  int nfail  = 0;

  // Model state, per instance (0 = round robin, 1 = fixed priority)
  int          cyc = 0;
  int          next_arb [2];
  bit          last     [2];
  bit          tx_act   [2];
  int          tx_acc   [2];
  bit          tx_win   [2];
  bit          tx_wr    [2];
  logic [4:0]  tx_addr  [2];
  logic [4:0]  tx_wd    [2];
  logic [11:0] tx_rd    [2];
  logic [11:0] ref_mem  [2][32];

  always #5 clock = ~clock;

  vsa_mem_arbiter #(.RR_EN(1'b1), .INIT_LAST(1'b0)) u_rr (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0), .if_valid(if_valid0),
    .if_rdata(if_rdata0), .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt0), .d_valid(d_valid0), .d_rdata(d_rdata0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(rd0)
  );

  vsa_mem_arbiter #(.RR_EN(1'b0), .INIT_LAST(1'b0)) u_fix (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_valid(if_valid1),
    .if_rdata(if_rdata1), .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(rd1)
  );

  function automatic logic [11:0] init_val(input int i);
    if (i == 6) return 12'h6A3;
    if (i == 3) return 12'hFFF;
    return 12'((i * 317) ^ 12'hA5A);
  endfunction

  // Behavioural memories: one-cycle read latency, write on strobe
  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= init_val(i);
        mem1[i] <= init_val(i);
      end
      mem_ready <= 1'b1;
    end else begin
      if (mem_en0) begin
        if (mem_we0) mem0[mem_addr0] <= mem_wdata0;
        rd0 <= mem0[mem_addr0];
      end
      if (mem_en1) begin
        if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
        rd1 <= mem1[mem_addr1];
      end
    end
  end

  task automatic chk(input string tag, input int k, input logic [11:0] obs,
                     input logic [11:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s dut%0d cyc%0d: got %h want %h", tag, k, cyc, obs, exp);
    end
  endtask

  // Transaction-level model: arbitration allowed two edges after a grant,
  // next edge after reset or an idle edge; memory effect applied at grant.
  task automatic model_edge();
    bit win;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        tx_act[k]   = 1'b0;
        last[k]     = 1'b0;
        next_arb[k] = cyc + 1;
      end else if (cyc >= next_arb[k]) begin
        if (if_req || d_req) begin
          if (if_req && d_req) win = (k == 0) ? !last[k] : 1'b1;
          else                 win = d_req;
          tx_act[k]  = 1'b1;
          tx_acc[k]  = cyc;
          tx_win[k]  = win;
          tx_wr[k]   = win && d_wr;
          tx_addr[k] = win ? d_addr : if_addr;
          tx_wd[k]   = d_wdata;
          tx_rd[k]   = ref_mem[k][tx_addr[k]];
          if (tx_wr[k]) ref_mem[k][tx_addr[k]] = {7'b0, d_wdata};
          last[k]     = win;
          next_arb[k] = cyc + 2;
        end else begin
          next_arb[k] = cyc + 1;
        end
      end
    end
  endtask

  task automatic check_cycle(input int k);
    logic g_if, g_d, v_if, v_d, en, we, acc, rsp;
    logic [4:0]  ma, drd;
    logic [11:0] wd, ird;
    if (k == 0) begin
      g_if = if_gnt0; g_d = d_gnt0; v_if = if_valid0; v_d = d_valid0;
      en = mem_en0; we = mem_we0; ma = mem_addr0; wd = mem_wdata0;
      ird = if_rdata0; drd = d_rdata0;
    end else begin
      g_if = if_gnt1; g_d = d_gnt1; v_if = if_valid1; v_d = d_valid1;
      en = mem_en1; we = mem_we1; ma = mem_addr1; wd = mem_wdata1;
      ird = if_rdata1; drd = d_rdata1;
    end
    acc = tx_act[k] && (cyc == tx_acc[k]);
    rsp = tx_act[k] && (cyc == tx_acc[k] + 1);
    chk("if_gnt",   k, 12'(g_if), 12'(acc && !tx_win[k]));
    chk("d_gnt",    k, 12'(g_d),  12'(acc && tx_win[k]));
    chk("mem_en",   k, 12'(en),   12'(acc));
    chk("mem_we",   k, 12'(we),   12'(acc && tx_wr[k]));
    if (acc) chk("mem_addr", k, 12'(ma), 12'(tx_addr[k]));
    if (!acc)          chk("mem_wdata", k, wd, 12'h000);
    else if (tx_win[k]) chk("mem_wdata", k, wd, {7'b0, tx_wd[k]});
    chk("if_valid", k, 12'(v_if), 12'(rsp && !tx_win[k]));
    chk("d_valid",  k, 12'(v_d),  12'(rsp && tx_win[k]));
    chk("if_rdata", k, ird, (rsp && !tx_win[k]) ? tx_rd[k] : 12'h000);
    chk("d_rdata",  k, 12'(drd),
        (rsp && tx_win[k] && !tx_wr[k]) ? 12'(tx_rd[k][4:0]) : 12'h000);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_cycle(0);
    check_cycle(1);
  endtask

  initial begin
    int gseq[$];
    int gcyc[$];
    bit exp_ord [4];
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};

    for (int k = 0; k < 2; k++) begin
      next_arb[k] = 0;
      last[k]     = 1'b0;
      tx_act[k]   = 1'b0;
      tx_acc[k]   = 0;
      for (int i = 0; i < 32; i++) ref_mem[k][i] = init_val(i);
    end

    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    step(); step();
    chk("rst_mem_en", 0, 12'(mem_en0), 12'h0);
    chk("rst_d_valid", 0, 12'(d_valid0), 12'h0);
    reset = 1'b0;
    step();

    // Single fetch from address 6
    if_req = 1'b1; if_addr = 5'd6;
    step();
    chk("fetch_gnt", 0, 12'(if_gnt0), 12'h1);
    chk("fetch_addr", 0, 12'(mem_addr0), 12'h006);
    if_req = 1'b0;
    step();
    chk("fetch_valid", 0, 12'(if_valid0), 12'h1);
    chk("fetch_rdata", 0, if_rdata0, 12'h6A3);
    step();

    // Store 0x15 to address 9
    d_req = 1'b1; d_wr = 1'b1; d_addr = 5'd9; d_wdata = 5'h15;
    step();
    chk("store_we", 0, 12'(mem_we0), 12'h1);
    chk("store_wdata", 0, mem_wdata0, 12'h015);
    d_req = 1'b0; d_wr = 1'b0;
    step();
    chk("store_ack", 0, 12'(d_valid0), 12'h1);
    chk("store_rdata", 0, 12'(d_rdata0), 12'h0);

    // Contention: both held through reset, then for 8 cycles
    if_req = 1'b1; d_req = 1'b1; if_addr = 5'd1; d_addr = 5'd2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (d_gnt0)  begin gseq.push_back(1); gcyc.push_back(i); end
      if (if_gnt0) begin gseq.push_back(0); gcyc.push_back(i); end
      chk("fix_no_if_gnt", 1, 12'(if_gnt1), 12'h0);
    end
    chk("rr_grant_count", 0, 12'(gseq.size()), 12'd4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) begin
      chk("rr_grant_order", 0, 12'(gseq[i]), 12'(exp_ord[i]));
      chk("rr_grant_cycle", 0, 12'(gcyc[i]), 12'(2 * i));
    end
    if_req = 1'b0; d_req = 1'b0;
    step(); step();

    // Reset during a load's ACCESS cycle
    d_req = 1'b1; d_wr = 1'b0; d_addr = 5'd12;
    step();
    chk("abort_gnt", 0, 12'(d_gnt0), 12'h1);
    d_req = 1'b0; reset = 1'b1;
    step();
    chk("abort_no_valid", 0, 12'(d_valid0), 12'h0);
    reset = 1'b0;
    step();
    chk("abort_idle", 0, 12'(d_valid0 | d_gnt0 | mem_en0), 12'h0);

    // Back-to-back loads from address 3 (holds 0xFFF)
    d_req = 1'b1; d_wr = 1'b0; d_addr = 5'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i % 2 == 1) chk("b2b_rdata", 0, 12'(d_rdata0), 12'h01F);
    end
    d_req = 1'b0;
    step();

    // Randomised traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 59) == 0);
      if_req  = ($urandom_range(0, 2) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_wr    = 1'($urandom);
      if_addr = 5'($urandom);
      d_addr  = 5'($urandom);
      d_wdata = 5'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
